rv32_multicycle_ctrl: RTL and testbench

Control unit for the multicycle RV32I core. It replaces the single-cycle opcode-to-controls lookup with a Moore/Mealy state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It supports a memory ready handshake with an optional timeout, optional JALR/AUIPC support, and a sticky fault on illegal opcodes. It sits between the instruction register (opcode field), the ALU zero flag and the shared instruction/data memory port.

---
 rtl/rv_ctrl_pkg.sv | 35 +++
 rtl/mc_timeout_ctr.sv | 20 ++
 rtl/rv32_multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_rv32_multicycle_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: state encoding, opcodes, datapath select codes and the decode dispatch shared by the multicycle control unit.
package rv_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BEQ, S_JAL, S_JALR1, S_JALR2, S_LUI, S_AUIPC, S_FAULT
  } state_e;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11;
  localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURES = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;
  localparam logic [1:0] CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10;
  function automatic state_e dispatch(input logic [6:0] op, input bit en_jalr, input bit en_auipc);
    case (op)
      OP_LW, OP_SW: return S_MEMADR;
      OP_R:         return S_EXECR;
      OP_I:         return S_EXECI;
      OP_BEQ:       return S_BEQ;
      OP_JAL:       return S_JAL;
      OP_JALR:      return en_jalr ? S_JALR1 : S_FAULT;
      OP_LUI:       return S_LUI;
      OP_AUIPC:     return en_auipc ? S_AUIPC : S_FAULT;
      default:      return S_FAULT;
    endcase
  endfunction
endpackage

// File: rtl/mc_timeout_ctr.sv
// mc_timeout_ctr: counts consecutive stalled memory cycles and flags the cycle that would reach MEM_TIMEOUT.
module mc_timeout_ctr #(
  parameter int MEM_TIMEOUT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (count_en) cnt_q <= cnt_q + 1'b1;
  end
  // A ready in the threshold cycle drops count_en, so completion beats the timeout
  assign expired = count_en && (cnt_q == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// rv32_multicycle_ctrl: multicycle RV32I control FSM with memory handshake, optional timeout and sticky fault.
module rv32_multicycle_ctrl import rv_ctrl_pkg::*; #(
  parameter bit EN_JALR     = 1'b1,
  parameter bit EN_AUIPC    = 1'b1,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       fault,
  output logic [1:0] fault_cause,
  output logic [3:0] state_dbg
);
  state_e state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic fault_q, expired, pc_update, branch;
  if (MEM_TIMEOUT > 0) begin : g_to
    mc_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_to (
      .clk(clk), .reset(reset), .clear(state_d != state_q),
      .count_en(mem_req & ~mem_ready), .expired(expired)
    );
  end else begin : g_no_to
    assign expired = 1'b0;
  end
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = dispatch(opcode, EN_JALR, EN_AUIPC);
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_JALR2, S_LUI, S_AUIPC: state_d = S_ALUWB;
      S_JALR1:    state_d = S_JALR2;
      default:    state_d = state_q;
    endcase
    if (state_q == S_DECODE && state_d == S_FAULT) cause_d = CAUSE_ILLEGAL;
    if (expired) begin
      state_d = S_FAULT;
      cause_d = CAUSE_TIMEOUT;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_NONE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      fault_q <= fault_q | (state_d == S_FAULT);
    end
  end
  always_comb begin
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALU_ADD;
    ImmSrc    = IMM_I;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALU_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALU_SUB;
        branch  = 1'b1;
      end
      S_JAL, S_JALR2: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_JALR1: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
      end
      default: ;
    endcase
  end
  assign PCWrite     = (branch & zero) | pc_update;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// tb_rv32_multicycle_ctrl: directed sequences checking state order, per-state controls, handshake, timeout and fault.
module tb_rv32_multicycle_ctrl;
  import rv_ctrl_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic rst_a, zero_a, rdy_a, rst_b, zero_b, rdy_b;
  logic [6:0] op_a, op_b;
  logic a_req, a_mw, a_as, a_ir, a_pw, a_rw, a_fault;
  logic [1:0] a_rs, a_sa, a_sb, a_op, a_cause;
  logic [2:0] a_imm;
  logic [3:0] a_st;
  logic b_req, b_mw, b_as, b_ir, b_pw, b_rw, b_fault;
  logic [1:0] b_rs, b_sa, b_sb, b_op, b_cause;
  logic [2:0] b_imm;
  logic [3:0] b_st;
  logic [16:0] ctl_a, ctl_b;
  assign ctl_a = {a_req, a_mw, a_as, a_ir, a_pw, a_rw, a_rs, a_sa, a_sb, a_op, a_imm};
  assign ctl_b = {b_req, b_mw, b_as, b_ir, b_pw, b_rw, b_rs, b_sa, b_sb, b_op, b_imm};
  rv32_multicycle_ctrl dut_a (
    .clk(clk), .reset(rst_a), .opcode(op_a), .zero(zero_a), .mem_ready(rdy_a),
    .mem_req(a_req), .MemWrite(a_mw), .AdrSrc(a_as), .IRWrite(a_ir), .PCWrite(a_pw),
    .RegWrite(a_rw), .ResultSrc(a_rs), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALUOp(a_op),
    .ImmSrc(a_imm), .fault(a_fault), .fault_cause(a_cause), .state_dbg(a_st)
  );
  rv32_multicycle_ctrl #(.EN_JALR(1'b1), .EN_AUIPC(1'b0), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .reset(rst_b), .opcode(op_b), .zero(zero_b), .mem_ready(rdy_b),
    .mem_req(b_req), .MemWrite(b_mw), .AdrSrc(b_as), .IRWrite(b_ir), .PCWrite(b_pw),
    .RegWrite(b_rw), .ResultSrc(b_rs), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALUOp(b_op),
    .ImmSrc(b_imm), .fault(b_fault), .fault_cause(b_cause), .state_dbg(b_st)
  );
  function automatic logic [16:0] mk(input bit req, mw, as, ir, pw, rw,
                                     input logic [1:0] rs, sa, sb, op, input logic [2:0] imm);
    return {req, mw, as, ir, pw, rw, rs, sa, sb, op, imm};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step_a(input string tag, input logic [3:0] st, input logic [16:0] c, input logic [2:0] fc);
    #1;
    chk({tag, "/state"}, 32'(a_st), 32'(st));
    chk({tag, "/ctl"}, 32'(ctl_a), 32'(c));
    chk({tag, "/fault"}, 32'({a_fault, a_cause}), 32'(fc));
    @(posedge clk);
    #1;
  endtask
  task automatic step_b(input string tag, input logic [3:0] st, input logic [16:0] c, input logic [2:0] fc);
    #1;
    chk({tag, "/state"}, 32'(b_st), 32'(st));
    chk({tag, "/ctl"}, 32'(ctl_b), 32'(c));
    chk({tag, "/fault"}, 32'({b_fault, b_cause}), 32'(fc));
    @(posedge clk);
    #1;
  endtask
  logic [16:0] c_f1, c_f0, c_dec, c_adr_lw, c_adr_sw, c_rd, c_mwb, c_wr, c_exr, c_exi, c_awb;
  logic [16:0] c_beq1, c_beq0, c_jal, c_jr1, c_lui, c_aui, c_off;
  initial begin
    c_f1     = mk(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    c_f0     = mk(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    c_dec    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010);
    c_adr_lw = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    c_adr_sw = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001);
    c_rd     = mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    c_mwb    = mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
    c_wr     = mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    c_exr    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000);
    c_exi    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000);
    c_awb    = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    c_beq1   = mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b000);
    c_beq0   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b000);
    c_jal    = mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000);
    c_jr1    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    c_lui    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00, 3'b100);
    c_aui    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b100);
    c_off    = '0;
    rst_a = 1'b1; rst_b = 1'b1; zero_a = 1'b0; zero_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    op_a = OP_LW; op_b = OP_R;
    #2;
    chk("reset/state", 32'(a_st), 32'd0);
    chk("reset/ctl", 32'(ctl_a), 32'(c_f0));
    chk("reset/fault", 32'({a_fault, a_cause}), 32'd0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    // lw, zero-wait memory
    rdy_a = 1'b1;
    step_a("lw.fetch", S_FETCH, c_f1, 3'b000);
    step_a("lw.decode", S_DECODE, c_dec, 3'b000);
    step_a("lw.memadr", S_MEMADR, c_adr_lw, 3'b000);
    step_a("lw.memread", S_MEMREAD, c_rd, 3'b000);
    step_a("lw.memwb", S_MEMWB, c_mwb, 3'b000);
    // sw with three stalled cycles in MEMWRITE
    op_a = OP_SW;
    step_a("sw.fetch", S_FETCH, c_f1, 3'b000);
    step_a("sw.decode", S_DECODE, c_dec, 3'b000);
    step_a("sw.memadr", S_MEMADR, c_adr_sw, 3'b000);
    rdy_a = 1'b0;
    for (int i = 0; i < 3; i++) step_a("sw.wait", S_MEMWRITE, c_wr, 3'b000);
    rdy_a = 1'b1;
    step_a("sw.done", S_MEMWRITE, c_wr, 3'b000);
    // reset in the middle of a stalled write
    step_a("sw2.fetch", S_FETCH, c_f1, 3'b000);
    step_a("sw2.decode", S_DECODE, c_dec, 3'b000);
    step_a("sw2.memadr", S_MEMADR, c_adr_sw, 3'b000);
    rdy_a = 1'b0;
    #1;
    chk("sw2.memwrite_mw", 32'(a_mw), 32'd1);
    rst_a = 1'b1;
    #1;
    chk("rst_mid/mw", 32'(a_mw), 32'd0);
    chk("rst_mid/state", 32'(a_st), 32'd0);
    chk("rst_mid/req", 32'(a_req), 32'd1);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    step_a("rst_rel", S_FETCH, c_f0, 3'b000);
    rdy_a = 1'b1;
    op_a = OP_R;
    step_a("r.fetch", S_FETCH, c_f1, 3'b000);
    step_a("r.decode", S_DECODE, c_dec, 3'b000);
    step_a("r.exec", S_EXECR, c_exr, 3'b000);
    step_a("r.wb", S_ALUWB, c_awb, 3'b000);
    op_a = OP_I;
    step_a("i.fetch", S_FETCH, c_f1, 3'b000);
    step_a("i.decode", S_DECODE, c_dec, 3'b000);
    step_a("i.exec", S_EXECI, c_exi, 3'b000);
    step_a("i.wb", S_ALUWB, c_awb, 3'b000);
    op_a = OP_BEQ; zero_a = 1'b1;
    step_a("beq1.fetch", S_FETCH, c_f1, 3'b000);
    step_a("beq1.decode", S_DECODE, c_dec, 3'b000);
    step_a("beq1.beq", S_BEQ, c_beq1, 3'b000);
    zero_a = 1'b0;
    step_a("beq0.fetch", S_FETCH, c_f1, 3'b000);
    step_a("beq0.decode", S_DECODE, c_dec, 3'b000);
    step_a("beq0.beq", S_BEQ, c_beq0, 3'b000);
    op_a = OP_JAL;
    step_a("jal.fetch", S_FETCH, c_f1, 3'b000);
    step_a("jal.decode", S_DECODE, c_dec, 3'b000);
    step_a("jal.jal", S_JAL, c_jal, 3'b000);
    step_a("jal.wb", S_ALUWB, c_awb, 3'b000);
    op_a = OP_JALR;
    step_a("jalr.fetch", S_FETCH, c_f1, 3'b000);
    step_a("jalr.decode", S_DECODE, c_dec, 3'b000);
    step_a("jalr.j1", S_JALR1, c_jr1, 3'b000);
    step_a("jalr.j2", S_JALR2, c_jal, 3'b000);
    step_a("jalr.wb", S_ALUWB, c_awb, 3'b000);
    op_a = OP_LUI;
    step_a("lui.fetch", S_FETCH, c_f1, 3'b000);
    step_a("lui.decode", S_DECODE, c_dec, 3'b000);
    step_a("lui.lui", S_LUI, c_lui, 3'b000);
    step_a("lui.wb", S_ALUWB, c_awb, 3'b000);
    op_a = OP_AUIPC;
    step_a("auipc.fetch", S_FETCH, c_f1, 3'b000);
    step_a("auipc.decode", S_DECODE, c_dec, 3'b000);
    step_a("auipc.auipc", S_AUIPC, c_aui, 3'b000);
    step_a("auipc.wb", S_ALUWB, c_awb, 3'b000);
    // timeout disabled: a long fetch stall must not fault
    rdy_a = 1'b0;
    for (int i = 0; i < 6; i++) step_a("stall.fetch", S_FETCH, c_f0, 3'b000);
    rdy_a = 1'b1; op_a = 7'b0001111;
    step_a("ill.fetch", S_FETCH, c_f1, 3'b000);
    step_a("ill.decode", S_DECODE, c_dec, 3'b000);
    for (int i = 0; i < 20; i++) begin
      rdy_a = 1'(i);
      zero_a = 1'b1;
      step_a("ill.fault", S_FAULT, c_off, 3'b101);
    end
    // second instance: EN_AUIPC=0, MEM_TIMEOUT=4
    rst_b = 1'b0;
    rdy_b = 1'b0;
    for (int i = 0; i < 3; i++) step_b("to.wait", S_FETCH, c_f0, 3'b000);
    rdy_b = 1'b1;
    step_b("to.ready4", S_FETCH, c_f1, 3'b000);
    step_b("to.decode", S_DECODE, c_dec, 3'b000);
    step_b("to.exec", S_EXECR, c_exr, 3'b000);
    step_b("to.wb", S_ALUWB, c_awb, 3'b000);
    rdy_b = 1'b0;
    for (int i = 0; i < 4; i++) step_b("to.stuck", S_FETCH, c_f0, 3'b000);
    step_b("to.fault", S_FAULT, c_off, 3'b110);
    rdy_b = 1'b1;
    step_b("to.fault_hold", S_FAULT, c_off, 3'b110);
    rst_b = 1'b1;
    #1;
    chk("b.reset/fault", 32'({b_fault, b_cause}), 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b0; op_b = OP_AUIPC;
    step_b("noauipc.fetch", S_FETCH, c_f1, 3'b000);
    step_b("noauipc.decode", S_DECODE, c_dec, 3'b000);
    step_b("noauipc.fault", S_FAULT, c_off, 3'b101);
    step_b("noauipc.hold", S_FAULT, c_off, 3'b101);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
